// File: rtl/evm_poll_controller_if.sv
// ---------------------------------------------------------------------------
// evm_poll_controller_if
//   Bundles the poll controller's control, vote handshake and result signals.
//   master : ballot front end (drives open/close/vote, observes results)
//   slave  : evm_poll_controller
//   Signals:
//     open_poll, close_poll   session control requests
//     vote_valid, vote_id     vote strobe and candidate index
//     vote_ack, vote_err      one-cycle accept / reject pulses
//     counts                  packed per-candidate counters
//     total_votes             accepted votes in the current poll
//     state                   IDLE=0 OPEN=1 TALLY=2 RESULT=3
//     winner_id, winner_valid, tie, overflow
// ---------------------------------------------------------------------------
interface evm_poll_controller_if #(
   parameter int unsigned NUM_CAND = 10,
   parameter int unsigned ID_W     = 4,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned TOT_W    = 12
);
   logic                      open_poll;
   logic                      close_poll;
   logic                      vote_valid;
   logic [ID_W-1:0]           vote_id;
   logic                      vote_ack;
   logic                      vote_err;
   logic [NUM_CAND*CNT_W-1:0] counts;
   logic [TOT_W-1:0]          total_votes;
   logic [1:0]                state;
   logic [ID_W-1:0]           winner_id;
   logic                      winner_valid;
   logic                      tie;
   logic                      overflow;

   modport master (
      output open_poll, close_poll, vote_valid, vote_id,
      input  vote_ack, vote_err, counts, total_votes, state,
             winner_id, winner_valid, tie, overflow
   );

   modport slave (
      input  open_poll, close_poll, vote_valid, vote_id,
      output vote_ack, vote_err, counts, total_votes, state,
             winner_id, winner_valid, tie, overflow
   );
endinterface

// File: rtl/evm_poll_controller.sv
// ---------------------------------------------------------------------------
// evm_poll_controller
//   Poll session controller for an N-candidate voting machine: opens and
//   closes a poll, accepts/rejects votes with a one-cycle ack/err pulse,
//   keeps per-candidate and total counters, then scans the counters one
//   candidate per cycle to report the winner (lowest index on a tie) and a
//   tie flag.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    evm_poll_controller_if.slave (control, votes, results)
//   Build option:
//     EVM_SATURATE_EN  counters saturate instead of wrapping and the sticky
//                      overflow flag is implemented; otherwise overflow = 0.
// ---------------------------------------------------------------------------
module evm_poll_controller #(
   parameter int unsigned NUM_CAND = 10,
   parameter int unsigned ID_W     = 4,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned TOT_W    = 12
) (
   input logic                   clk,
   input logic                   reset,
   evm_poll_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OPEN   = 2'd1,
      TALLY  = 2'd2,
      RESULT = 2'd3
   } state_e;

   // One extra bit so NUM_CAND == 2^ID_W still compares correctly.
   localparam logic [ID_W:0]   NUM_CAND_L = (ID_W+1)'(NUM_CAND);
   localparam logic [ID_W-1:0] LAST_IDX   = ID_W'(NUM_CAND-1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q [NUM_CAND];
   logic [TOT_W-1:0] total_q;
   logic             ack_q;
   logic             err_q;
   logic [ID_W-1:0]  winner_q;
   logic             tie_q;
   logic [ID_W-1:0]  scan_q;
   logic [CNT_W-1:0] max_q;
`ifdef EVM_SATURATE_EN
   logic             ovf_q;
   logic             ovf_d;
`endif

   logic             id_ok;
   logic [CNT_W-1:0] sel_cnt;
   logic [CNT_W-1:0] cnt_d;
   logic [TOT_W-1:0] total_d;
   logic [CNT_W-1:0] scan_cnt;

   // Next values for the counters touched by an accepted vote.
   always_comb begin
      id_ok    = ({1'b0, bus.vote_id} < NUM_CAND_L);
      sel_cnt  = id_ok ? cnt_q[bus.vote_id] : '0;
      scan_cnt = cnt_q[scan_q];
`ifdef EVM_SATURATE_EN
      cnt_d    = (sel_cnt == '1) ? sel_cnt : sel_cnt + CNT_W'(1);
      total_d  = (total_q == '1) ? total_q : total_q + TOT_W'(1);
      ovf_d    = (sel_cnt == '1) || (total_q == '1);
`else
      cnt_d    = sel_cnt + CNT_W'(1);
      total_d  = total_q + TOT_W'(1);
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         for (int unsigned i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
         total_q  <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         winner_q <= '0;
         tie_q    <= 1'b0;
         scan_q   <= '0;
         max_q    <= '0;
`ifdef EVM_SATURATE_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE, RESULT: begin
               if (bus.vote_valid) err_q <= 1'b1;
               if (bus.open_poll) begin
                  state_q  <= OPEN;
                  for (int unsigned i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
                  total_q  <= '0;
                  winner_q <= '0;
                  tie_q    <= 1'b0;
`ifdef EVM_SATURATE_EN
                  ovf_q    <= 1'b0;
`endif
               end
            end
            OPEN: begin
               // A vote on the closing cycle still counts; close wins over open.
               if (bus.vote_valid) begin
                  if (id_ok) begin
                     cnt_q[bus.vote_id] <= cnt_d;
                     total_q            <= total_d;
                     ack_q              <= 1'b1;
`ifdef EVM_SATURATE_EN
                     if (ovf_d) ovf_q <= 1'b1;
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               if (bus.close_poll) begin
                  state_q <= TALLY;
                  scan_q  <= '0;
               end
            end
            TALLY: begin
               if (bus.vote_valid) err_q <= 1'b1;
               // Index 0 seeds the running maximum; later equals only flag a tie.
               if (scan_q == '0 || scan_cnt > max_q) begin
                  max_q    <= scan_cnt;
                  winner_q <= scan_q;
                  tie_q    <= 1'b0;
               end else if (scan_cnt == max_q) begin
                  tie_q <= 1'b1;
               end
               if (scan_q == LAST_IDX) state_q <= RESULT;
               else                    scan_q  <= scan_q + ID_W'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.counts = '0;
      for (int unsigned i = 0; i < NUM_CAND; i++) begin
         bus.counts[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

   assign bus.vote_ack     = ack_q;
   assign bus.vote_err     = err_q;
   assign bus.total_votes  = total_q;
   assign bus.state        = state_q;
   assign bus.winner_id    = winner_q;
   assign bus.winner_valid = (state_q == RESULT);
   assign bus.tie          = tie_q;
`ifdef EVM_SATURATE_EN
   assign bus.overflow     = ovf_q;
`else
   assign bus.overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_evm_poll_controller.sv
// ---------------------------------------------------------------------------
// tb_evm_poll_controller
//   Directed and randomized poll sessions against a behavioural model of the
//   poll controller, plus a narrow-counter instance for wrap/saturation.
// ---------------------------------------------------------------------------
module tb_evm_poll_controller;
   localparam int unsigned N  = 10;
   localparam int unsigned IW = 4;
   localparam int unsigned CW = 8;
   localparam int unsigned TW = 12;
`ifdef EVM_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   evm_poll_controller_if #(.NUM_CAND(N), .ID_W(IW), .CNT_W(CW), .TOT_W(TW)) bus ();
   evm_poll_controller #(.NUM_CAND(N), .ID_W(IW), .CNT_W(CW), .TOT_W(TW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   evm_poll_controller_if #(.NUM_CAND(4), .ID_W(2), .CNT_W(2), .TOT_W(3)) bus2 ();
   evm_poll_controller #(.NUM_CAND(4), .ID_W(2), .CNT_W(2), .TOT_W(3)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   int total_n = 0;
   int bad_n   = 0;

   // Reference model state
   int ms;            // 0 idle, 1 open, 2 tally, 3 result
   int mcnt [N];
   int mtot, mack, merr, mwin, mtie, movf, mleft;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_n++;
      assert (obs === exp) else begin
         bad_n++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      mtot = 0; mwin = 0; mtie = 0; movf = 0;
   endtask

   task automatic model_reset();
      model_clear();
      ms = 0; mack = 0; merr = 0; mleft = 0;
   endtask

   task automatic find_winner();
      int mx, neq;
      mx = -1; neq = 0;
      for (int i = 0; i < N; i++)
         if (mcnt[i] > mx) begin mx = mcnt[i]; mwin = i; end
      for (int i = 0; i < N; i++)
         if (mcnt[i] == mx) neq++;
      mtie = (neq >= 2) ? 1 : 0;
   endtask

   task automatic model_step(input bit op, input bit cp, input bit vv, input int id);
      int lc, lt;
      lc = (1 << CW) - 1;
      lt = (1 << TW) - 1;
      mack = 0; merr = 0;
      case (ms)
         0, 3: begin
            if (vv) merr = 1;
            if (op) begin model_clear(); ms = 1; end
         end
         1: begin
            if (vv) begin
               if (id < N) begin
                  mack = 1;
                  if (SAT) begin
                     if (mcnt[id] + 1 > lc || mtot + 1 > lt) movf = 1;
                     mcnt[id] = (mcnt[id] + 1 > lc) ? lc : mcnt[id] + 1;
                     mtot     = (mtot + 1 > lt) ? lt : mtot + 1;
                  end else begin
                     mcnt[id] = (mcnt[id] + 1) % (lc + 1);
                     mtot     = (mtot + 1) % (lt + 1);
                  end
               end else begin
                  merr = 1;
               end
            end
            if (cp) begin ms = 2; mleft = N; end
         end
         default: begin
            if (vv) merr = 1;
            mleft--;
            if (mleft == 0) begin ms = 3; find_winner(); end
         end
      endcase
   endtask

   task automatic check_all();
      logic [CW-1:0] c;
      chk("state", bus.state, ms);
      chk("vote_ack", bus.vote_ack, mack);
      chk("vote_err", bus.vote_err, merr);
      chk("total_votes", bus.total_votes, mtot);
      chk("winner_valid", bus.winner_valid, (ms == 3) ? 1 : 0);
      chk("overflow", bus.overflow, movf);
      for (int i = 0; i < N; i++) begin
         c = bus.counts[i*CW +: CW];
         chk($sformatf("count%0d", i), c, mcnt[i]);
      end
      if (ms != 2) begin
         chk("winner_id", bus.winner_id, mwin);
         chk("tie", bus.tie, mtie);
      end
   endtask

   task automatic cyc(input bit op, input bit cp, input bit vv, input logic [IW-1:0] id);
      bus.open_poll  = op;
      bus.close_poll = cp;
      bus.vote_valid = vv;
      bus.vote_id    = id;
      model_step(op, cp, vv, int'(id));
      @(posedge clk);
      #1;
      bus.open_poll  = 1'b0;
      bus.close_poll = 1'b0;
      bus.vote_valid = 1'b0;
      bus.vote_id    = '0;
      check_all();
   endtask

   task automatic vote(input int id);
      cyc(1'b0, 1'b0, 1'b1, IW'(id));
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      int nv, acks;
      bus.open_poll = 1'b0; bus.close_poll = 1'b0; bus.vote_valid = 1'b0; bus.vote_id = '0;
      bus2.open_poll = 1'b0; bus2.close_poll = 1'b0; bus2.vote_valid = 1'b0; bus2.vote_id = '0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk) reset = 1'b1;

      // Vote in IDLE is rejected, then the reference session
      vote(3);
      cyc(1'b1, 1'b0, 1'b0, '0);
      vote(4); vote(2); vote(2); vote(9); vote(4);
      vote(12); vote(15);
      cyc(1'b0, 1'b1, 1'b0, '0);
      idle_n(N);
      chk("plan1_winner", bus.winner_id, 2);
      chk("plan1_tie", bus.tie, 1);
      chk("plan1_total", bus.total_votes, 5);

      // RESULT: votes rejected, close ignored, open restarts with clears
      vote(1);
      cyc(1'b0, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, '0);

      // Vote coincident with close still counts
      vote(7); vote(3);
      cyc(1'b0, 1'b1, 1'b1, 4'd7);
      idle_n(N);
      chk("close_vote_winner", bus.winner_id, 7);
      chk("close_vote_tie", bus.tie, 0);

      // open alone ignored in OPEN; open+close -> close wins; TALLY ignores controls
      cyc(1'b1, 1'b0, 1'b0, '0);
      vote(1);
      cyc(1'b1, 1'b0, 1'b0, '0);
      vote(6);
      cyc(1'b1, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b1, 4'd2);
      idle_n(N - 1);

      // Randomized sessions
      for (int p = 0; p < 4; p++) begin
         cyc(1'b1, 1'b0, 1'b0, '0);
         nv = $urandom_range(20, 60);
         for (int v = 0; v < nv; v++)
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), IW'($urandom_range(0, 15)));
         cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), IW'($urandom_range(0, 15)));
         idle_n(N);
      end

      // Counter limit on the default width
      cyc(1'b1, 1'b0, 1'b0, '0);
      for (int v = 0; v < 257; v++) vote(5);
      vote(1);
      cyc(1'b0, 1'b1, 1'b0, '0);
      idle_n(N);

      // Reset during the 4th TALLY cycle
      cyc(1'b1, 1'b0, 1'b0, '0);
      vote(8);
      cyc(1'b0, 1'b1, 1'b0, '0);
      idle_n(3);
      reset = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk) reset = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, '0);
      vote(0);
      cyc(1'b0, 1'b1, 1'b0, '0);
      idle_n(N);
      chk("post_reset_winner", bus.winner_id, 0);
      chk("post_reset_tie", bus.tie, 0);

      // Narrow counters: five votes for candidate 3 with CNT_W=2
      bus2.open_poll = 1'b1;
      @(posedge clk); #1;
      bus2.open_poll = 1'b0;
      chk("d2_state", bus2.state, 1);
      acks = 0;
      for (int v = 0; v < 5; v++) begin
         bus2.vote_valid = 1'b1;
         bus2.vote_id    = 2'd3;
         @(posedge clk); #1;
         bus2.vote_valid = 1'b0;
         if (bus2.vote_ack === 1'b1) acks++;
      end
      chk("d2_acks", acks, 5);
      chk("d2_count3", bus2.counts[7:6], SAT ? 3 : 1);
      chk("d2_overflow", bus2.overflow, SAT ? 1 : 0);
      chk("d2_total", bus2.total_votes, 5);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end
endmodule

// File: doc/evm_poll_controller.md
# evm_poll_controller

Parametrised successor to the ten-candidate electronic voting machine. It adds:
- a poll session state machine (open, close, tally, result);
- a vote valid/acknowledge handshake with invalid-ID rejection;
- an N-candidate packed count bus with a running total;
- a sequential tally engine that reports the winner and a tie flag.

It sits between the ballot-entry front end (keypad or debouncer) and the results display or readout logic.

## Interface
Parameters:
- NUM_CAND, 10, number of candidates (2..16)
- ID_W, 4, width of vote_id; must satisfy 2^ID_W >= NUM_CAND
- CNT_W, 8, width of each per-candidate counter
- TOT_W, 12, width of the total-vote counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- open_poll  in  1  single-cycle request to start a new poll
- close_poll  in  1  single-cycle request to end voting and start the tally
- vote_valid  in  1  vote strobe; one vote per cycle in which it is high
- vote_id  in  ID_W  candidate index, sampled when vote_valid=1
- vote_ack  out  1  one-cycle pulse: vote accepted
- vote_err  out  1  one-cycle pulse: vote rejected
- counts  out  NUM_CAND*CNT_W  packed counters; candidate i occupies bits [i*CNT_W +: CNT_W]
- total_votes  out  TOT_W  number of accepted votes in this poll
- state  out  2  IDLE=0, OPEN=1, TALLY=2, RESULT=3
- winner_id  out  ID_W  index of the highest count; lowest index wins on a tie
- winner_valid  out  1  high while in RESULT
- tie  out  1  high in RESULT when two or more candidates share the maximum count
- overflow  out  1  sticky flag: some counter hit its limit (only with the Configuration macro)

## Operation
Reset value of every output: 0. The state machine starts in IDLE.

State machine:
- IDLE: open_poll -> OPEN. All counts, total_votes, winner_id, tie and overflow clear on the same edge.
- OPEN: vote_valid=1 with vote_id < NUM_CAND:
  - counts[vote_id] and total_votes each increment by 1;
  - vote_ack pulses.
- OPEN: vote_valid=1 with vote_id >= NUM_CAND: vote_err pulses; no counter changes.
- OPEN: close_poll -> TALLY.
  - If vote_valid is also high on that cycle, the vote is still processed.
  - If open_poll and close_poll are high together, close_poll wins.
  - open_poll alone in OPEN is ignored.
- TALLY: scans candidates 0..NUM_CAND-1, one per cycle.
  - Keeps a running maximum and its index.
  - A strictly greater count replaces the maximum and clears the tie flag.
  - An equal count sets the tie flag and keeps the earlier index.
  - After the last index -> RESULT.
- RESULT: winner_valid=1; winner_id and tie hold. open_poll -> OPEN (clears as in IDLE).
- Votes outside OPEN: vote_err pulses, nothing is counted. open_poll and close_poll are ignored during TALLY.
- All counters read 0 at close: winner_id=0, tie=1 (NUM_CAND >= 2).
- Counter arithmetic without the Configuration macro: unsigned, modulo 2^CNT_W (per candidate) and 2^TOT_W (total).

## Timing
- Vote: vote_valid sampled at edge k. The counter update and the ack/err pulse are visible after edge k. ack/err last exactly one cycle.
- Back-to-back votes on consecutive cycles are all counted. There is no back-pressure.
- Tally:
  - close_poll sampled at edge k -> state=TALLY after k.
  - Candidate i is examined at edge k+1+i.
  - state=RESULT and winner_valid=1 after edge k+NUM_CAND (NUM_CAND cycles of TALLY).
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset assertion at any time, including mid-TALLY, immediately forces all outputs to 0 and state to IDLE.

## Configuration
- Macro: EVM_SATURATE_EN.
- Defined:
  - Each counter saturates at 2^CNT_W-1, and total_votes saturates at 2^TOT_W-1.
  - A vote that would exceed the limit still pulses vote_ack but leaves that counter at its maximum.
  - overflow sets and stays set until reset or open_poll.
- Undefined:
  - Counters wrap.
  - overflow is tied to 0.

## Test plan
- Reset, open_poll, votes 4,2,2,9,4, then close_poll (defaults):
  - count2=2, count4=2, count9=1, total_votes=5, five ack pulses;
  - after 10 TALLY cycles: winner_id=2, tie=1, winner_valid=1.
- In OPEN, vote_id=12 then 15 -> two vote_err pulses; counts and total unchanged. A vote while in IDLE or RESULT -> vote_err, nothing counted.
- close_poll and vote_valid (id 7) on the same cycle -> count7 increments; state=TALLY on the next cycle; winner_id=7 if it is the unique maximum, tie=0.
- CNT_W=2, five votes for candidate 3:
  - with EVM_SATURATE_EN: count3=3, overflow=1, five acks;
  - without: count3=1, overflow=0.
- Reset asserted on the 4th TALLY cycle -> state=IDLE, all outputs 0. A new open_poll, one vote for id 0, then close_poll -> winner_id=0, tie=0.
- From RESULT, open_poll -> counts, total, tie and winner_valid clear on that edge; state=OPEN.
